// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state encoding for the mul/div sequencer
//
// Contents:
//   OP_MUL / OP_DIV  operation select encoding
//   state_t          sequencer states ST_IDLE, ST_RUN, ST_DONE
//   LAST_ITER        counter value of the final iteration
//   DZ_QUOTIENT      quotient reported for divide-by-zero
package muldiv_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LAST_ITER = 15;

  localparam logic [15:0] DZ_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/alu_muldiv_ctrl_if.sv
// rtl/alu_muldiv_ctrl_if.sv - request/result and ALU-drive bundle for alu_muldiv_ctrl
//
// Signals:
//   start, op, opa, opb             request from the execute stage
//   busy, done, res_hi, res_lo, dz  status and results
//   alu_m, alu_a, alu_b             drive to the shared ALU
//   alu_s, alu_cout                 returned from the shared ALU
//   res_n, res_z, res_v             result flags, present only with MULDIV_FLAGS_EN
// Modports:
//   slave  - the sequencer's view
//   master - the environment's view (execute stage plus ALU)
interface alu_muldiv_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             dz;
  logic             alu_m;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_s;
  logic             alu_cout;

`ifdef MULDIV_FLAGS_EN
  logic             res_n;
  logic             res_z;
  logic             res_v;

  modport slave (
    input  start, op, opa, opb, alu_s, alu_cout,
    output busy, done, res_hi, res_lo, dz, alu_m, alu_a, alu_b,
    output res_n, res_z, res_v
  );

  modport master (
    output start, op, opa, opb, alu_s, alu_cout,
    input  busy, done, res_hi, res_lo, dz, alu_m, alu_a, alu_b,
    input  res_n, res_z, res_v
  );
`else
  modport slave (
    input  start, op, opa, opb, alu_s, alu_cout,
    output busy, done, res_hi, res_lo, dz, alu_m, alu_a, alu_b
  );

  modport master (
    output start, op, opa, opb, alu_s, alu_cout,
    input  busy, done, res_hi, res_lo, dz, alu_m, alu_a, alu_b
  );
`endif

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add / restoring-divide iteration around the external ALU
//
// Purely combinational.
// Ports:
//   i_op              OP_MUL or OP_DIV
//   i_hi, i_lo        working pair: P_hi/P_lo for MUL, R/Q for DIV
//   i_b               MC for MUL, D for DIV
//   i_alu_s/i_alu_cout  ALU result for the drive produced here
//   o_alu_m/a/b       ALU drive
//   o_nxt_hi/o_nxt_lo working pair after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_alu_s,
  input  logic             i_alu_cout,
  output logic             o_alu_m,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [WIDTH-1:0] o_nxt_hi,
  output logic [WIDTH-1:0] o_nxt_lo
);

  logic [WIDTH-1:0] w_rs;
  logic             w_rmsb;

  // Remainder shifted left with the next dividend bit; the bit shifted out
  // of R is the 17th bit of Rs, which makes Rs >= D regardless of cout.
  assign w_rs   = {i_hi[WIDTH-2:0], i_lo[WIDTH-1]};
  assign w_rmsb = i_hi[WIDTH-1];

  always_comb begin
    o_alu_m  = 1'b0;
    o_alu_a  = '0;
    o_alu_b  = '0;
    o_nxt_hi = i_hi;
    o_nxt_lo = i_lo;
    if (i_op == OP_MUL) begin
      o_alu_m  = 1'b0;
      o_alu_a  = i_hi;
      o_alu_b  = i_lo[0] ? i_b : '0;
      // 33-bit {cout, S, P_lo} shifted right by one
      o_nxt_hi = {i_alu_cout, i_alu_s[WIDTH-1:1]};
      o_nxt_lo = {i_alu_s[0], i_lo[WIDTH-1:1]};
    end else begin
      o_alu_m = 1'b1;
      o_alu_a = w_rs;
      o_alu_b = i_b;
      if (w_rmsb || i_alu_cout) begin
        o_nxt_hi = i_alu_s;
        o_nxt_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_nxt_hi = w_rs;
        o_nxt_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// rtl/alu_muldiv_ctrl.sv - multi-cycle unsigned 16x16 multiply / 16/16 divide sequencer over a shared add/sub ALU
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   alu_muldiv_ctrl_if.slave: start/op/opa/opb in, busy/done/res_hi/res_lo/dz out,
//         alu_m/alu_a/alu_b to the ALU, alu_s/alu_cout from the ALU
// Optional: define MULDIV_FLAGS_EN to add registered result flags res_n/res_z/res_v.
// Latency: done 17 cycles after an accepted start, 1 cycle for divide-by-zero.
module alu_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  alu_muldiv_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_nxt_state;
  logic             r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_dz;

  logic             w_run;
  logic             w_last;
  logic             w_div0;
  logic             w_step_m;
  logic [WIDTH-1:0] w_step_a;
  logic [WIDTH-1:0] w_step_b;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = (r_cnt == CNT_W'(LAST_ITER));
  assign w_div0 = (bus.op == OP_DIV) && (bus.opb == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_op       (r_op),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .i_b        (r_b),
    .i_alu_s    (bus.alu_s),
    .i_alu_cout (bus.alu_cout),
    .o_alu_m    (w_step_m),
    .o_alu_a    (w_step_a),
    .o_alu_b    (w_step_b),
    .o_nxt_hi   (w_nxt_hi),
    .o_nxt_lo   (w_nxt_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_nxt_state = w_div0 ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last)    w_nxt_state = ST_DONE;
      ST_DONE: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

`ifdef MULDIV_FLAGS_EN
  logic r_res_n;
  logic r_res_z;
  logic r_res_v;
`endif

  // Results are captured on the edge that enters DONE so they are already
  // valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dz     <= 1'b0;
`ifdef MULDIV_FLAGS_EN
      r_res_n  <= 1'b0;
      r_res_z  <= 1'b0;
      r_res_v  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op  <= bus.op;
            r_hi  <= '0;
            r_lo  <= (bus.op == OP_MUL) ? bus.opb : bus.opa;
            r_b   <= (bus.op == OP_MUL) ? bus.opa : bus.opb;
            r_cnt <= '0;
            r_dz  <= 1'b0;
            if (w_div0) begin
              r_dz     <= 1'b1;
              r_res_hi <= bus.opa;
              r_res_lo <= DZ_QUOTIENT;
`ifdef MULDIV_FLAGS_EN
              r_res_n  <= DZ_QUOTIENT[15];
              r_res_z  <= 1'b0;
              r_res_v  <= 1'b1;
`endif
            end
          end
        end
        ST_RUN: begin
          r_hi  <= w_nxt_hi;
          r_lo  <= w_nxt_lo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_res_hi <= w_nxt_hi;
            r_res_lo <= w_nxt_lo;
`ifdef MULDIV_FLAGS_EN
            if (r_op == OP_MUL) begin
              r_res_n <= w_nxt_hi[WIDTH-1];
              r_res_z <= ({w_nxt_hi, w_nxt_lo} == '0);
              r_res_v <= (w_nxt_hi != '0);
            end else begin
              r_res_n <= w_nxt_lo[WIDTH-1];
              r_res_z <= (w_nxt_lo == '0);
              r_res_v <= r_dz;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.res_hi = r_res_hi;
  assign bus.res_lo = r_res_lo;
  assign bus.dz     = r_dz;
  // ALU inputs are parked at zero outside RUN
  assign bus.alu_m  = w_run ? w_step_m : 1'b0;
  assign bus.alu_a  = w_run ? w_step_a : '0;
  assign bus.alu_b  = w_run ? w_step_b : '0;

`ifdef MULDIV_FLAGS_EN
  assign bus.res_n  = r_res_n;
  assign bus.res_z  = r_res_z;
  assign bus.res_v  = r_res_v;
`endif

endmodule
